clk_glitch_alarm_mgr: RTL
=========================

Name: clk_glitch_alarm_mgr

Overview:
- Consumes the raw alarm outputs of N pulse-delay-line clock-glitch sensors. Each sensor's alarm is the XOR of two flops sampled through a delay line.
- Filters spurious alarms during post-reset warm-up and applies a hit-count-in-window threshold. Raises a halt request plus interrupt to the core, and holds a lockdown state until software clears it.
- Sits between the sensor array and the core's debug/halt and interrupt logic.

Parameters:
- N_SENSORS, 3, number of sensor alarm inputs (≥1).
- WARMUP_CYCLES, 4, cycles after reset/clear during which alarms are ignored (≥1).
- THRESH, 2, hit cycles within one window needed to trigger (1..WINDOW).
- WINDOW, 16, length of the hit-accumulation window in cycles (≥1).
- CNT_W, 8, width of the event counter and timestamp.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- alarm_i  in  N_SENSORS  raw sensor alarms, asynchronous-ish combinational XORs; registered internally.
- sensor_en_i  in  N_SENSORS  per-sensor enable mask.
- clr_i  in  1  software clear pulse.
- halt_ack_i  in  1  core acknowledges halt.
- halt_req_o  out  1  halt request to core.
- irq_o  out  1  level interrupt.
- alarm_sticky_o  out  N_SENSORS  per-sensor sticky alarm flags.
- event_cnt_o  out  CNT_W  saturating count of hit cycles since reset.
- state_o  out  2  FSM state: 0 WARMUP, 1 MONITOR, 2 ALERT, 3 LOCKED.

Behaviour:
- Reset is rst_n, synchronous, active-low; clock is clk.
- Reset values: state=WARMUP, halt_req_o=0, irq_o=0, alarm_sticky_o=0, event_cnt_o=0, internal alarm_q=0, hit count=0, window count=0, warm-up count=0.
- alarm_q <= alarm_i every cycle, including during WARMUP.
- hit is 1 when (alarm_q & sensor_en_i) != 0 and state is not WARMUP.
- WARMUP:
  - Counts WARMUP_CYCLES cycles, then goes to MONITOR.
  - Alarms are ignored: no sticky update, no counting.
- MONITOR, on hit:
  - Set sticky bits: alarm_sticky_o |= alarm_q & sensor_en_i.
  - event_cnt_o increments and saturates at 2^CNT_W-1.
  - hit count increments.
- Window rule:
  - A hit with hit count=0 opens the window and the window counter starts at 0.
  - The window counter increments each cycle while the window is open.
  - At window count WINDOW-1 with no trigger: hit count is reset to 0 and the window closes. A hit in that same cycle counts as the first hit of a new window.
- Trigger: when hit count+hit reaches THRESH, go to ALERT at that edge.
  - Latency: alarm_i high at edge k gives halt_req_o=1 and irq_o=1 after edge k+1 when THRESH=1.
- ALERT:
  - halt_req_o=1 and irq_o=1.
  - Sticky bits and event_cnt_o keep updating.
  - halt_ack_i=1 moves to LOCKED; halt_req_o deasserts at that edge.
  - clr_i is ignored in ALERT.
- LOCKED:
  - irq_o=1 and halt_req_o=0.
  - Sticky bits and event_cnt_o keep updating.
  - clr_i=1 goes to WARMUP and clears the sticky bits, hit count and window. event_cnt_o is kept. irq_o drops at that edge.
- clr_i in MONITOR clears the sticky bits, hit count and window, and the state stays MONITOR. If clr_i and a hit occur in the same cycle, the clear wins: the hit is not counted and sets no sticky bit, but event_cnt_o still increments.
- halt_ack_i outside ALERT is ignored.
- Reset mid-operation (any state) returns all state to reset values in the next cycle.
- sensor_en_i changes take effect in the same cycle's hit evaluation.

Optional Feature:
- Macro: GLITCH_EVENT_LOG_EN.
- When defined:
  - Adds a free-running CNT_W timestamp counter, reset to 0, wrapping.
  - Adds outputs first_idx_o [$clog2(N_SENSORS) max 1], first_ts_o [CNT_W] and log_valid_o [1].
  - The first hit after reset or a clear captures the lowest set index of alarm_q & sensor_en_i and the timestamp, and sets log_valid_o=1.
  - The log is frozen until reset or an accepted clr_i, which clears log_valid_o, first_idx_o and first_ts_o to 0.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, alarm_i=3'b111 held for cycles 0..3 → no sticky bits, event_cnt_o=0; state_o=1 after 4 cycles.
- MONITOR, THRESH=2, alarm_i[1] single 1-cycle pulse, then none for 20 cycles → sticky=3'b010, event_cnt_o=1, state stays MONITOR; a second pulse 17 cycles later does not trigger.
- Two pulses on alarm_i[0] 5 cycles apart → state ALERT, halt_req_o=irq_o=1; halt_ack_i pulse → LOCKED, halt_req_o=0, irq_o=1.
- LOCKED, clr_i pulse → state WARMUP, irq_o=0, sticky=0, event_cnt_o unchanged (2); alarms for the next 4 cycles are ignored.
- sensor_en_i=3'b011, alarm_i=3'b100 continuously → no hits, sticky=0, no trigger; then enable bit 2 → trigger after 2 hit cycles.
- With GLITCH_EVENT_LOG_EN, simultaneous pulse on alarm_i=3'b110 at timestamp 9 → first_idx_o=1, first_ts_o=9 (registered-sample timestamp), log_valid_o=1; later hits leave the log unchanged.

Source files
------------

// File: rtl/clk_glitch_alarm_mgr.sv
// Clock-glitch sensor alarm manager: warm-up masking, hit-count-in-window trigger,
// halt/irq escalation and software-cleared lockdown. Optional event log: GLITCH_EVENT_LOG_EN.
module clk_glitch_alarm_mgr #(
    parameter int N_SENSORS     = 3,
    parameter int WARMUP_CYCLES = 4,
    parameter int THRESH        = 2,
    parameter int WINDOW        = 16,
    parameter int CNT_W         = 8,
    localparam int IDX_W        = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SENSORS-1:0] alarm_i,
    input  logic [N_SENSORS-1:0] sensor_en_i,
    input  logic                 clr_i,
    input  logic                 halt_ack_i,
    output logic                 halt_req_o,
    output logic                 irq_o,
    output logic [N_SENSORS-1:0] alarm_sticky_o,
    output logic [CNT_W-1:0]     event_cnt_o,
    output logic [1:0]           state_o
`ifdef GLITCH_EVENT_LOG_EN
    ,
    output logic                 log_valid_o,
    output logic [IDX_W-1:0]     first_idx_o,
    output logic [CNT_W-1:0]     first_ts_o
`endif
);

    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int HIT_W  = $clog2(THRESH + 1);

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        MONITOR = 2'd1,
        ALERT   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [N_SENSORS-1:0] alarm_q;
    logic [N_SENSORS-1:0] masked;
    logic [N_SENSORS-1:0] sticky_q;
    logic [CNT_W-1:0]     event_cnt_q;
    logic [HIT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
    logic [WARM_W-1:0]    warm_cnt_q;
    logic                 hit;
    logic                 clr_acc;
    logic                 trig;
    logic [31:0]          hit_sum;

    assign masked  = alarm_q & sensor_en_i;
    assign hit     = (|masked) && (state_q != WARMUP);
    assign hit_sum = 32'(hit_cnt_q) + 32'(hit);

    always_comb begin
        state_d = state_q;
        clr_acc = 1'b0;
        trig    = 1'b0;
        case (state_q)
            WARMUP:  if (warm_cnt_q == WARM_W'(WARMUP_CYCLES - 1)) state_d = MONITOR;
            MONITOR: begin
                // A clear in the same cycle as a hit suppresses the hit's trigger effect.
                if (clr_i) begin
                    clr_acc = 1'b1;
                end else if (hit && (hit_sum >= 32'(THRESH))) begin
                    trig    = 1'b1;
                    state_d = ALERT;
                end
            end
            ALERT:   if (halt_ack_i) state_d = LOCKED;
            LOCKED: begin
                if (clr_i) begin
                    clr_acc = 1'b1;
                    state_d = WARMUP;
                end
            end
            default: state_d = WARMUP;
        endcase
    end

    // The window is open exactly while hit_cnt_q is non-zero.
    always_comb begin
        hit_cnt_d = '0;
        win_cnt_d = '0;
        if (state_q == MONITOR && !clr_acc && !trig) begin
            if (hit_cnt_q != '0) begin
                if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
                    hit_cnt_d = hit ? HIT_W'(1) : '0;
                    win_cnt_d = '0;
                end else begin
                    hit_cnt_d = hit ? hit_cnt_q + HIT_W'(1) : hit_cnt_q;
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                end
            end else if (hit) begin
                hit_cnt_d = HIT_W'(1);
                win_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WARMUP;
            alarm_q     <= '0;
            sticky_q    <= '0;
            event_cnt_q <= '0;
            hit_cnt_q   <= '0;
            win_cnt_q   <= '0;
            warm_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            alarm_q   <= alarm_i;
            hit_cnt_q <= hit_cnt_d;
            win_cnt_q <= win_cnt_d;
            if (state_q == WARMUP && state_d == WARMUP) begin
                warm_cnt_q <= warm_cnt_q + WARM_W'(1);
            end else begin
                warm_cnt_q <= '0;
            end
            if (clr_acc) begin
                sticky_q <= '0;
            end else if (hit) begin
                sticky_q <= sticky_q | masked;
            end
            if (hit && (event_cnt_q != {CNT_W{1'b1}})) begin
                event_cnt_q <= event_cnt_q + CNT_W'(1);
            end
        end
    end

    assign halt_req_o     = (state_q == ALERT);
    assign irq_o          = (state_q == ALERT) || (state_q == LOCKED);
    assign alarm_sticky_o = sticky_q;
    assign event_cnt_o    = event_cnt_q;
    assign state_o        = state_q;

`ifdef GLITCH_EVENT_LOG_EN
    logic [CNT_W-1:0] ts_q;
    logic [IDX_W-1:0] low_idx;
    logic             log_valid_q;
    logic [IDX_W-1:0] first_idx_q;
    logic [CNT_W-1:0] first_ts_q;

    always_comb begin
        low_idx = '0;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (masked[i]) low_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q        <= '0;
            log_valid_q <= 1'b0;
            first_idx_q <= '0;
            first_ts_q  <= '0;
        end else begin
            ts_q <= ts_q + CNT_W'(1);
            if (clr_acc) begin
                log_valid_q <= 1'b0;
                first_idx_q <= '0;
                first_ts_q  <= '0;
            end else if (hit && !log_valid_q) begin
                log_valid_q <= 1'b1;
                first_idx_q <= low_idx;
                first_ts_q  <= ts_q;
            end
        end
    end

    assign log_valid_o = log_valid_q;
    assign first_idx_o = first_idx_q;
    assign first_ts_o  = first_ts_q;
`endif

endmodule
